ls20_self_test_controller: RTL
==============================

// Module: ls20_self_test_controller
// PURPOSE
//  Self-test sequencer for a dual 4-input NAND gate (74LS20 model) on the same clock domain.
//  On start it steps a 4-bit vector through all 16 input codes and drives both gates with each one.
//  Gate 1 gets vec; gate 2 gets ~vec, so a cross-wired gate is detected.
//  After a settle window it checks Y1/Y2 against NAND expectations and reports pass/fail and error details.
// PARAMETERS
//  SETTLE_CYCLES  4  clk cycles between driving a vector and sampling Y; 0..255; must cover gate delay
//  STOP_ON_FAIL   0  1: end the sweep at the first mismatching vector; 0: always run all 16 vectors
// PORTS
//  clk        in   1  rising-edge clock
//  reset      in   1  synchronous, active-high
//  start      in   1  1-cycle request to begin a sweep; ignored unless in IDLE
//  busy       out  1  high from the first APPLY to the last CHECK inclusive
//  done       out  1  1-cycle pulse when the sweep ends
//  pass       out  1  result of the last completed sweep; held until next start
//  A1,B1,C1,D1 out 1  gate-1 inputs = vec[3],vec[2],vec[1],vec[0]
//  A2,B2,C2,D2 out 1  gate-2 inputs = ~vec[3],~vec[2],~vec[1],~vec[0]
//  Y1,Y2      in   1  gate outputs under test
//  err_cnt    out  5  number of vectors with any mismatch (0..16)
//  fail_vec   out  4  vec value at the first mismatch; 0 if none
//  fail_gate  out  2  {Y2 bad, Y1 bad} captured at the first mismatch; 0 if none
// BEHAVIOUR
//  Reset: FSM goes to IDLE; vec, settle counter, all gate inputs, busy, done, pass, err_cnt, fail_vec, fail_gate = 0.
//  FSM: IDLE -> APPLY -> WAIT -> CHECK -> (APPLY | FINISH) -> IDLE.
//  IDLE: gate inputs held at vec=0 encoding. On start=1: clear err_cnt, fail_*, pass; vec=0; go to APPLY.
//  APPLY (1 cycle): gate inputs register from vec; load settle counter with SETTLE_CYCLES.
//    If SETTLE_CYCLES=0, go directly to CHECK.
//  WAIT (SETTLE_CYCLES cycles): count down; leave when the counter reaches 1.
//  CHECK (1 cycle):
//    exp1 = ~&vec; exp2 = ~&(~vec), i.e. exp2 = 0 only when vec=0.
//    m = {Y2!=exp2, Y1!=exp1}.
//    If m!=0: err_cnt++ (maximum 16, no wrap).
//    If m!=0 and this is the first error: fail_vec=vec, fail_gate=m.
//    Next state: if vec==15, or (STOP_ON_FAIL and m!=0), go to FINISH; else vec++ and go to APPLY.
//  FINISH (1 cycle): done=1; pass=(err_cnt==0) after the update; busy=0; go to IDLE.
//  Latency from the start-sampling edge to done high is V*(SETTLE_CYCLES+2)+1 cycles, V = vectors run.
//    Full run with the default: 16*6+1 = 97.
//  start while not IDLE: ignored, with no restart or queueing. start in the FINISH cycle: ignored.
//  Reset in any state aborts the sweep the next edge; results are cleared and no done pulse is issued.
//  Y1/Y2 are sampled only in CHECK. Metastability is not handled because the DUT is synchronous to clk.
//  Outputs are all registered; no combinational path from Y to any output.
// TESTING
//  T1: good gate model, zero delay, SETTLE=4, pulse start
//      -> done at cycle 97; pass=1; err_cnt=0; fail_vec=0; fail_gate=0.
//  T2: Y1 stuck at 1
//      -> one error at vec=15; pass=0; err_cnt=1; fail_vec=15; fail_gate=2'b01; done at cycle 97.
//  T3: Y1 and Y2 both stuck at 0
//      -> every vector mismatches; err_cnt=16; fail_vec=0; fail_gate=2'b01; pass=0.
//  T4: STOP_ON_FAIL=1, Y2 stuck at 1
//      -> stop at vec=0; done at cycle 7; err_cnt=1; fail_gate=2'b10.
//  T5: start pulsed again at cycle 30 while busy -> ignored; the sweep completes normally at cycle 97.
//  T6: reset asserted at cycle 40, then start -> all outputs 0 the cycle after reset; the new sweep passes at 97.

Source files
------------

// File: rtl/ls20_self_test_controller_if.sv
// Signal bundle between the LS20 self-test controller and the requester / gate under test.
// The requester (master) drives start and the gate outputs; the controller (slave) drives the rest.
interface ls20_self_test_controller_if;
  logic       start;
  logic       busy;
  logic       done;
  logic       pass;
  logic       A1, B1, C1, D1;
  logic       A2, B2, C2, D2;
  logic       Y1, Y2;
  logic [4:0] err_cnt;
  logic [3:0] fail_vec;
  logic [1:0] fail_gate;

  modport master (
    output start, Y1, Y2,
    input  busy, done, pass, A1, B1, C1, D1, A2, B2, C2, D2,
    input  err_cnt, fail_vec, fail_gate
  );

  modport slave (
    input  start, Y1, Y2,
    output busy, done, pass, A1, B1, C1, D1, A2, B2, C2, D2,
    output err_cnt, fail_vec, fail_gate
  );
endinterface

// File: rtl/ls20_self_test_controller.sv
// Exhaustive self-test sequencer for a dual 4-input NAND (74LS20): sweeps all 16 codes,
// drives gate 1 with vec and gate 2 with ~vec, and checks Y1/Y2 after a settle window.
module ls20_self_test_controller #(
  parameter int SETTLE_CYCLES = 4,
  parameter int STOP_ON_FAIL  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  ls20_self_test_controller_if.slave    bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_APPLY  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_CHECK  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [7:0] SETTLE  = 8'(SETTLE_CYCLES);
  localparam logic [4:0] ERR_MAX = 5'd16;

  logic [2:0] state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gin_q, gin_d;   // {A1,B1,C1,D1,A2,B2,C2,D2}
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [1:0] fail_gate_q, fail_gate_d;

  logic       exp1, exp2;
  logic [1:0] mis;

  // exp2 is low only for vec=0, where gate 2 sees all ones
  assign exp1 = ~&vec_q;
  assign exp2 = ~&(~vec_q);
  assign mis  = {bus.Y2 != exp2, bus.Y1 != exp1};

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    gin_d       = gin_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    err_cnt_d   = err_cnt_q;
    fail_vec_d  = fail_vec_q;
    fail_gate_d = fail_gate_q;

    case (state_q)
      S_IDLE: begin
        gin_d = {4'b0000, 4'b1111};
        if (bus.start) begin
          err_cnt_d   = '0;
          fail_vec_d  = '0;
          fail_gate_d = '0;
          pass_d      = 1'b0;
          vec_d       = '0;
          busy_d      = 1'b1;
          state_d     = S_APPLY;
        end
      end
      S_APPLY: begin
        gin_d   = {vec_q, ~vec_q};
        cnt_d   = SETTLE;
        state_d = (SETTLE == 8'd0) ? S_CHECK : S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q <= 8'd1) state_d = S_CHECK;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_CHECK: begin
        if (mis != 2'b00) begin
          if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + 5'd1;
          if (err_cnt_q == 5'd0) begin
            fail_vec_d  = vec_q;
            fail_gate_d = mis;
          end
        end
        if (vec_q == 4'hF || (STOP_ON_FAIL != 0 && mis != 2'b00)) begin
          busy_d  = 1'b0;
          state_d = S_FINISH;
        end else begin
          vec_d   = vec_q + 4'd1;
          state_d = S_APPLY;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        pass_d  = (err_cnt_q == 5'd0);
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vec_q       <= '0;
      cnt_q       <= '0;
      gin_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      fail_vec_q  <= '0;
      fail_gate_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      gin_q       <= gin_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      fail_vec_q  <= fail_vec_d;
      fail_gate_q <= fail_gate_d;
    end
  end

  assign {bus.A1, bus.B1, bus.C1, bus.D1} = gin_q[7:4];
  assign {bus.A2, bus.B2, bus.C2, bus.D2} = gin_q[3:0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.fail_vec  = fail_vec_q;
  assign bus.fail_gate = fail_gate_q;

endmodule
